// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate self-test engines.
package gate_test_pkg;

  typedef enum logic [1:0] {StIdle = 2'd0, StWait = 2'd1, StDone = 2'd2} gate_state_e;

  localparam logic [1:0] ST_IDLE = StIdle;
  localparam logic [1:0] ST_WAIT = StWait;
  localparam logic [1:0] ST_DONE = StDone;

  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

  // Number of input vectors for a gate with n_in inputs.
  function automatic int unsigned nv(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/gate_settle_cnt.sv
// Loadable down-counter with a zero flag; holds at zero.
module gate_settle_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Exhaustive truth-table checker: walks every input vector into a gate under test
// and scores its output against EXP_TT.
module gate_tt_checker
  import gate_test_pkg::*;
#(
  parameter int unsigned          N_IN   = 2,
  parameter logic [nv(N_IN)-1:0] EXP_TT = TT_NAND2,
  parameter int unsigned          SETTLE = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  output logic [N_IN-1:0]     dut_in_o,
  input  logic                dut_y_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [N_IN:0]       err_cnt_o,
  output logic [nv(N_IN)-1:0] fail_vec_o
);

  localparam int unsigned     NV        = nv(N_IN);
  localparam logic [3:0]      SettleVal = 4'(SETTLE);
  localparam logic [N_IN-1:0] LastIdx   = N_IN'(NV - 1);

  logic [1:0]      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN:0]   err_q, err_d;
  logic [NV-1:0]   fail_q, fail_d;
  logic            pass_q, pass_d;
  logic            cnt_load, cnt_dec, cnt_zero, mismatch;

  gate_settle_cnt #(
    .Width(4)
  ) u_settle_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(SettleVal),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  assign mismatch = (dut_y_i != EXP_TT[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          idx_d    = '0;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Abort wins over a compare due on the same edge; partial scores are kept.
        if (abort_i) begin
          idx_d   = '0;
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          if (mismatch) begin
            err_d         = err_q + 1'b1;
            fail_d[idx_q] = 1'b1;
          end
          if (idx_q == LastIdx) begin
            pass_d  = (err_d == '0);
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + 1'b1;
            cnt_load = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in_o   = idx_q;
  assign busy_o     = (state_q == ST_WAIT);
  assign done_o     = (state_q == ST_DONE);
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_q;
  assign fail_vec_o = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed and randomized runs of the truth-table checker against a behavioural GUT model.
module tb_gate_tt_checker;
  import gate_test_pkg::*;

  localparam int S  = 2;
  localparam int NV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] dut_in;
  logic       dut_y;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;
  logic [3:0] gut_tt = 4'b0111;

  logic       start2 = 1'b0;
  logic       abort2 = 1'b0;
  logic [0:0] inv_in;
  logic       inv_y, busy2, done2, pass2;
  logic [1:0] err2, fail2;

  int total = 0;
  int bad   = 0;

  assign dut_y = gut_tt[dut_in];
  assign inv_y = ~inv_in[0];

  always #5 clk = ~clk;

  gate_tt_checker u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .dut_in_o  (dut_in),
    .dut_y_i   (dut_y),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass),
    .err_cnt_o (err_cnt),
    .fail_vec_o(fail_vec)
  );

  gate_tt_checker #(
    .N_IN  (1),
    .EXP_TT(2'b01),
    .SETTLE(0)
  ) u_inv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start2),
    .abort_i   (abort2),
    .dut_in_o  (inv_in),
    .dut_y_i   (inv_y),
    .busy_o    (busy2),
    .done_o    (done2),
    .pass_o    (pass2),
    .err_cnt_o (err2),
    .fail_vec_o(fail2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Vector k is scored on edge (k+1)*(S+1) after the start edge; an abort seen on
  // or before that edge drops it.
  function automatic logic [3:0] ref_fail(input logic [3:0] gtt, input int abort_at);
    logic [3:0] exp_tt;
    logic [3:0] f;
    exp_tt = TT_NAND2;
    f = '0;
    for (int k = 0; k < NV; k++) begin
      if ((gtt[k] != exp_tt[k]) && ((abort_at < 0) || ((k + 1) * (S + 1) < abort_at))) begin
        f[k] = 1'b1;
      end
    end
    return f;
  endfunction

  task automatic do_run(input logic [3:0] gtt, input int abort_at, input int restart_at);
    int         done_at;
    int         dones;
    logic [3:0] ef;
    done_at = -1;
    dones   = 0;
    gut_tt  = gtt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("dut_in_vec0", dut_in, 0);
    for (int e = 1; e <= 20; e++) begin
      abort = (e == abort_at);
      start = (e == restart_at);
      @(posedge clk);
      #1;
      abort = 1'b0;
      start = 1'b0;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = e;
      end
      if ((e < NV * (S + 1)) && ((abort_at < 0) || (e < abort_at))) begin
        check("dut_in_step", dut_in, e / (S + 1));
      end
      if (e == abort_at) begin
        check("abort_busy", busy, 0);
        check("abort_dut_in", dut_in, 0);
      end
    end
    ef = ref_fail(gtt, abort_at);
    if (abort_at < 0) begin
      // Counting the start edge itself as the first edge.
      check("done_latency", done_at + 1, NV * (S + 1) + 1);
      check("done_count", dones, 1);
    end else begin
      check("abort_no_done", dones, 0);
    end
    check("fail_vec", fail_vec, ef);
    check("err_cnt", err_cnt, $countones(ef));
    check("pass", pass, (abort_at < 0) && (ef == 4'b0000));
  endtask

  initial begin
    int ab;
    int done_at;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fail", fail_vec, 0);
    check("rst_dut_in", dut_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // start together with abort in idle is refused
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);

    do_run(4'b0111, -1, -1);  // NAND GUT
    do_run(4'b1111, -1, -1);  // stuck-at-1
    do_run(4'b1000, -1, -1);  // AND GUT
    do_run(4'b0111, -1, -1);  // clean restart
    do_run(4'b0000, 9, -1);   // abort on vector 2's compare edge
    do_run(4'b1000, -1, 5);   // start re-pulsed while busy

    for (int i = 0; i < 6; i++) begin
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1;
      do_run(4'($urandom), ab, -1);
    end

    // asynchronous reset mid-run
    gut_tt = 4'b1000;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_reset_err", err_cnt, 2);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_err", err_cnt, 0);
    check("async_rst_fail", fail_vec, 0);
    check("async_rst_dut_in", dut_in, 0);
    check("async_rst_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_run(4'b0111, -1, -1);

    // inverter, SETTLE=0, one input
    done_at = -1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (done2 && (done_at < 0)) done_at = e;
    end
    check("inv_done_latency", done_at + 1, 3);
    check("inv_pass", pass2, 1);
    check("inv_err", err2, 0);
    check("inv_fail", fail2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Stimulus-and-check engine for the team's combinational gate library; the driving end of a gate's a/b -> y interface.
- On `start`, drives every input combination into a gate under test (GUT), waits a settle time, samples the GUT output and compares it against a parameterised truth table.
- Reports a pass flag, an error count and a per-vector fail map.
- Sits in the self-test wrapper around nand/and/or/xor gate instances; defaults check a 2-input NAND.

Parameters:
- N_IN, 2, number of GUT inputs (1..4); number of vectors NV = 2**N_IN.
- EXP_TT, 4'b0111, expected output, NV bits. Bit i is the expected y when the GUT inputs equal i, so bit 3 is for a=1,b=1. The MSB input is `dut_in[N_IN-1]`.
- SETTLE, 2, wait cycles after each input change before sampling (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel an active run.
- dut_in  out  N_IN  GUT inputs; for N_IN=2, {a,b} = dut_in[1:0].
- dut_y  in  1  GUT output.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  last completed run had zero mismatches.
- err_cnt  out  N_IN+1  mismatch count of the current or last run.
- fail_vec  out  NV  bit i set if vector i mismatched.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, settle counter=0.
  - A reset mid-run discards the run; no done is produced.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a clk edge with start=1 and abort=0: idx<=0, dut_in<=0, cnt<=SETTLE, err_cnt<=0, fail_vec<=0, pass<=0, busy<=1, go to WAIT.
  - start=1 together with abort=1 in IDLE: stay in IDLE.
- WAIT:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: compare dut_y with EXP_TT[idx] at this edge.
    - On mismatch: err_cnt<=err_cnt+1 and fail_vec[idx]<=1.
    - If idx==NV-1: go to DONE.
    - Otherwise: idx<=idx+1, dut_in<=idx+1, cnt<=SETTLE.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles.
  - dut_y is sampled SETTLE+1 edges after dut_in changes.
- DONE (one cycle):
  - done=1, busy=0.
  - pass<=(err_cnt==0), using the final count including the last compare.
  - Return to IDLE next edge.
  - pass, err_cnt and fail_vec hold until the next accepted start or reset.
- Latency: done is high during the cycle that begins NV*(SETTLE+1)+1 edges after the start edge. With defaults: 4*3+1 = 13.
- start while busy (WAIT/DONE): ignored, no restart, no effect on counters.
- abort=1 in WAIT:
  - Next edge returns to IDLE with busy<=0, dut_in<=0, pass<=0.
  - err_cnt and fail_vec keep their partial values.
  - done is not pulsed.
  - abort in DONE is ignored; the run completes.
- abort has priority over a compare scheduled on the same edge; that compare is not recorded.
- err_cnt cannot overflow: at most NV, which fits in N_IN+1 bits.
- dut_y is treated as synchronous; the GUT must be combinational from dut_in, with no resynchroniser.
- SETTLE=0 is legal: one cycle per vector, and the compare happens on the edge after dut_in changes.
- dut_in is glitch-free: it changes only on clock edges, by register.

Decomposition:
- Shared package gate_test_pkg:
  - state enum {IDLE, WAIT, DONE}.
  - Function nv(N_IN) returning 2**N_IN.
  - Named truth-table constants: TT_NAND2=4'b0111, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_NOR2=4'b0001, TT_XOR2=4'b0110, TT_XNOR2=4'b1001.
- One natural sub-module, gate_settle_cnt: a loadable down-counter with a zero flag, reused by later multi-cycle gate testers.
- Everything else (FSM, index, scoreboard) stays in the top module.

Test Plan:
- Defaults, GUT = NAND model; start pulse at edge 0 -> dut_in steps 0,1,2,3 every 3 cycles; done high in cycle 13; pass=1, err_cnt=0, fail_vec=4'b0000.
- GUT stuck-at-1 (dut_y=1), EXP_TT=TT_NAND2 -> pass=0, err_cnt=1, fail_vec=4'b1000.
- GUT = AND model, EXP_TT=TT_NAND2 -> err_cnt=4, fail_vec=4'b1111, pass=0; then restart with a NAND GUT -> counters cleared at start, pass=1.
- abort asserted during vector 2 with a stuck-at-0 GUT -> busy drops next edge, no done pulse, dut_in=0, err_cnt=2, fail_vec=4'b0011 (vector 2 not recorded).
- start re-pulsed while busy, then rst_n pulsed low mid-run -> the re-pulse is ignored; on reset all outputs go to 0 immediately (asynchronously), and a following start runs a full clean pass.
- SETTLE=0, N_IN=1, EXP_TT=2'b01 (inverter), GUT=inverter -> done high 3 edges after start, pass=1.
